// File: rtl/decoder_n_scan.sv
// One-hot decoder with a loadable index and an automatic scan mode.
// Optional macro DECODER_N_SCAN_DWELL_EN holds each scanned output for DWELL cycles.
module decoder_n_scan #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic                load,
    input  logic                scan,
    input  logic [N-1:0]        x,
    output logic [(1<<N)-1:0]   z,
    output logic [N-1:0]        sel,
    output logic                wrap,
    output logic                dbg_mode
);

    localparam int M = 1 << N;
    localparam logic [N-1:0] IDX_MAX = N'(M - 1);

    typedef enum logic {
        HOLD = 1'b0,
        SCAN = 1'b1
    } mode_t;

    mode_t          r_mode;
    mode_t          w_mode_next;
    logic [N-1:0]   r_idx;
    logic [N-1:0]   w_idx_next;
    logic [M-1:0]   r_z;
    logic [M-1:0]   w_z_next;
    logic           r_wrap;
    logic           w_adv;
    logic           w_dwell_done;

`ifdef DECODER_N_SCAN_DWELL_EN
    logic [7:0]     r_cnt;
    logic [7:0]     w_cnt_next;

    assign w_dwell_done = (r_cnt == 8'(DWELL - 1));
`else
    // Without the dwell build every enabled scan cycle steps; DWELL has no effect.
    assign w_dwell_done = (DWELL > 0) | 1'b1;
`endif

    // Dropping scan freezes the index in the same cycle the mode returns to HOLD.
    assign w_adv = (r_mode == SCAN) && scan && en && !load && w_dwell_done;

    always_comb begin
        w_idx_next = r_idx;
        if (load) begin
            w_idx_next = x;
        end else if (w_adv) begin
            w_idx_next = r_idx + N'(1);
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        if (load) begin
            w_mode_next = scan ? SCAN : HOLD;
        end else if (r_mode == HOLD && scan) begin
            w_mode_next = SCAN;
        end else if (r_mode == SCAN && !scan) begin
            w_mode_next = HOLD;
        end
    end

    always_comb begin
        w_z_next = '0;
        if (en) begin
            w_z_next[w_idx_next] = 1'b1;
        end
    end

`ifdef DECODER_N_SCAN_DWELL_EN
    always_comb begin
        w_cnt_next = r_cnt;
        if (load) begin
            w_cnt_next = 8'd0;
        end else if (r_mode == HOLD && scan) begin
            w_cnt_next = 8'd0;
        end else if (w_adv) begin
            w_cnt_next = 8'd0;
        end else if (r_mode == SCAN && scan && en) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode <= HOLD;
            r_idx  <= '0;
            r_z    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_mode <= w_mode_next;
            r_idx  <= w_idx_next;
            r_z    <= w_z_next;
            r_wrap <= w_adv && (r_idx == IDX_MAX);
        end
    end

    assign z        = r_z;
    assign sel      = r_idx;
    assign wrap     = r_wrap;
    assign dbg_mode = r_mode;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Directed bench for decoder_n_scan (N=2); follows DECODER_N_SCAN_DWELL_EN when defined.
module tb_decoder_n_scan;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic       load  = 1'b0;
    logic       scan  = 1'b0;
    logic [1:0] x     = 2'd0;
    logic [3:0] z;
    logic [1:0] sel;
    logic       wrap;
    logic       dbg_mode;

    int tests_run    = 0;
    int tests_failed = 0;

    decoder_n_scan #(.N(2), .DWELL(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .scan     (scan),
        .x        (x),
        .z        (z),
        .sel      (sel),
        .wrap     (wrap),
        .dbg_mode (dbg_mode)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (z !== 4'b0000) begin tests_failed++; $display("FAIL reset_z got=%b exp=0000", z); end
        tests_run++;
        if (sel !== 2'd0) begin tests_failed++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        tests_run++;
        if (wrap !== 1'b0) begin tests_failed++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        tests_run++;
        if (dbg_mode !== 1'b0) begin tests_failed++; $display("FAIL reset_mode got=%b exp=0", dbg_mode); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load();
        en = 1'b1; load = 1'b1; x = 2'd2; scan = 1'b0;
        tick();
        load = 1'b0;
        tests_run++;
        if (z !== 4'b0100) begin tests_failed++; $display("FAIL load_z got=%b exp=0100", z); end
        tests_run++;
        if (sel !== 2'd2) begin tests_failed++; $display("FAIL load_sel got=%0d exp=2", sel); end
        tests_run++;
        if (wrap !== 1'b0) begin tests_failed++; $display("FAIL load_wrap got=%b exp=0", wrap); end
    endtask

    task automatic test_enable();
        load = 1'b1; x = 2'd3;
        tick();
        load = 1'b0; en = 1'b0;
        tick();
        tests_run++;
        if (z !== 4'b0000) begin tests_failed++; $display("FAIL en_off_z got=%b exp=0000", z); end
        tests_run++;
        if (sel !== 2'd3) begin tests_failed++; $display("FAIL en_off_sel got=%0d exp=3", sel); end
        // load still captured while disabled, z stays dark
        load = 1'b1; x = 2'd1;
        tick();
        load = 1'b0;
        tests_run++;
        if (sel !== 2'd1 || z !== 4'b0000) begin
            tests_failed++; $display("FAIL en_off_load got sel=%0d z=%b exp sel=1 z=0000", sel, z);
        end
        load = 1'b1; x = 2'd3;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        tests_run++;
        if (z !== 4'b1000) begin tests_failed++; $display("FAIL en_on_z got=%b exp=1000", z); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] xs [4]  = '{2'd0, 2'd3, 2'd1, 2'd2};
        logic [3:0] exp [4] = '{4'b0001, 4'b1000, 4'b0010, 4'b0100};
        scan = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load = 1'b1; x = xs[i];
            tick();
            tests_run++;
            if (z !== exp[i] || wrap !== 1'b0) begin
                tests_failed++; $display("FAIL b2b_%0d got z=%b wrap=%b exp z=%b wrap=0", i, z, wrap, exp[i]);
            end
        end
        load = 1'b0;
    endtask

`ifdef DECODER_N_SCAN_DWELL_EN
    task automatic test_scan();
        logic [3:0] ez;
        en = 1'b1; load = 1'b1; x = 2'd0; scan = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ez = 4'b0001 << ((k / 4) % 4);
            tests_run++;
            if (z !== ez || wrap !== (k == 16)) begin
                tests_failed++; $display("FAIL scan_k%0d got z=%b wrap=%b exp z=%b wrap=%b", k, z, wrap, ez, (k == 16));
            end
            tick();
        end
    endtask

    task automatic test_midscan();
        logic [3:0] ez [8] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
        logic       en_seq [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        load = 1'b1; x = 2'd1; scan = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (z !== ez[k]) begin
                tests_failed++; $display("FAIL midscan_k%0d got z=%b exp=%b", k, z, ez[k]);
            end
            en = en_seq[k];
            tick();
        end
        en = 1'b1;
    endtask
`else
    task automatic test_scan();
        logic [3:0] ez [8] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic       ew [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        en = 1'b1; load = 1'b1; x = 2'd2; scan = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (z !== ez[k] || wrap !== ew[k]) begin
                tests_failed++; $display("FAIL scan_k%0d got z=%b wrap=%b exp z=%b wrap=%b", k, z, wrap, ez[k], ew[k]);
            end
            if (k < 7) tick();
        end
        // z=0010 now; dropping scan freezes the index
        scan = 1'b0;
        tick();
        tests_run++;
        if (z !== 4'b0010 || dbg_mode !== 1'b0) begin
            tests_failed++; $display("FAIL scan_stop got z=%b mode=%b exp z=0010 mode=0", z, dbg_mode);
        end
    endtask

    task automatic test_midscan();
        load = 1'b1; x = 2'd1; scan = 1'b1;
        tick();
        load = 1'b0;
        tests_run++;
        if (z !== 4'b0010) begin tests_failed++; $display("FAIL midscan_load got z=%b exp=0010", z); end
        tick();
        tests_run++;
        if (z !== 4'b0100) begin tests_failed++; $display("FAIL midscan_step got z=%b exp=0100", z); end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (z !== 4'b0000 || sel !== 2'd2) begin
                tests_failed++; $display("FAIL midscan_off%0d got z=%b sel=%0d exp z=0000 sel=2", k, z, sel);
            end
        end
        en = 1'b1;
        tick();
        tests_run++;
        if (z !== 4'b1000) begin tests_failed++; $display("FAIL midscan_resume got z=%b exp=1000", z); end
    endtask
`endif

    task automatic test_async_reset();
        en = 1'b1; scan = 1'b1; load = 1'b1; x = 2'd3;
        tick();
        load = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (z !== 4'b0000 || sel !== 2'd0 || wrap !== 1'b0) begin
            tests_failed++; $display("FAIL async_reset got z=%b sel=%0d wrap=%b exp 0000/0/0", z, sel, wrap);
        end
        tests_run++;
        if (dbg_mode !== 1'b0) begin tests_failed++; $display("FAIL async_reset_mode got=%b exp=0", dbg_mode); end
        #1;
        reset = 1'b0;
        tick();
        tests_run++;
        if (z !== 4'b0001 || sel !== 2'd0 || dbg_mode !== 1'b1) begin
            tests_failed++; $display("FAIL post_reset got z=%b sel=%0d mode=%b exp 0001/0/1", z, sel, dbg_mode);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_enable();
        test_back_to_back();
        test_scan();
        test_midscan();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
